regfile_bypass_param: RTL and testbench
=======================================

Name: regfile_bypass_param

Overview:
- Parametrised successor to the datapath's 32x32 register file: configurable data width and depth, two combinational read ports, one write port.
- Writes are clocked on rising Clk; same-cycle write-to-read forwarding replaces the old negedge-write trick.
- Adds asynchronous reset to defined initial contents, a protected-register mask, and a sticky protection-violation flag with a saturating counter.
- Sits in the ID stage of the pipelined MIPS datapath; the WB stage drives the write port.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- PROT_MASK, 32'h0C000001, bit i set => register i is write-protected ($0, $26, $27).
- INIT_LO, 2, first register given a counting initial value.
- INIT_HI, 25, last register given a counting initial value.
- INIT_OFFSET, 100, register i (INIT_LO..INIT_HI) resets to i+INIT_OFFSET.
- SP_IDX, 29, stack-pointer register index.
- SP_INIT, 1020, stack-pointer reset value.
- CNT_W, 8, violation counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- ReadReg1  in  ADDR_W  read address, port 1.
- ReadReg2  in  ADDR_W  read address, port 2.
- WAddr  in  ADDR_W  write address.
- WData  in  DATA_W  write data, signed.
- RegWrite  in  1  write enable.
- ClearViolation  in  1  synchronous clear of WriteViolation and ViolationCount.
- ReadData1  out  DATA_W  read data, port 1, signed.
- ReadData2  out  DATA_W  read data, port 2, signed.
- WriteViolation  out  1  sticky: set when a write targets a protected register.
- ViolationCount  out  CNT_W  count of blocked writes, saturating.

Behaviour:
- Interface: one clock, Clk; reset Reset_n is asynchronous and active-low.
- Reset (Reset_n=0, async, takes effect mid-cycle):
  - Registers INIT_LO..INIT_HI = i+INIT_OFFSET; register SP_IDX = SP_INIT; all others = 0.
  - WriteViolation=0, ViolationCount=0.
  - All state holds these values while Reset_n=0; writes are ignored.
- Write: a write is legal when RegWrite=1 and PROT_MASK[WAddr]=0. A legal write updates Registers[WAddr] <= WData on rising Clk.
- Blocked write: RegWrite=1 and PROT_MASK[WAddr]=1.
  - Register contents are unchanged.
  - WriteViolation <= 1.
  - ViolationCount <= ViolationCount+1, holding at 2**CNT_W-1 once reached.
- ClearViolation=1 at rising Clk clears the flag and the counter. If a blocked write occurs in the same cycle, the clear applies first: result is flag=1, count=1.
- Read ports are combinational, zero latency, and evaluated independently:
  - If ReadRegX==0, ReadDataX=0, regardless of bypass.
  - Else if the write is legal and WAddr==ReadRegX, ReadDataX=WData (bypass).
  - Else ReadDataX=Registers[ReadRegX].
- Protected registers are readable and return their reset value forever; they are never bypassed.
- Both ports may read the same address, including the address being written.
- RegWrite=0: no state change except a ClearViolation clear.
- Depth smaller than 32 (ADDR_W<5): PROT_MASK bits above depth-1 are ignored. INIT_HI and SP_IDX must be < depth; the bench checks this with an elaboration-time assertion.

Test Plan:
- Reset -> ReadReg1=5 gives 105; ReadReg2=29 gives 1020; reg 1 reads 0; reg 31 reads 0; WriteViolation=0; ViolationCount=0.
- RegWrite=1, WAddr=8, WData=-7, ReadReg1=8 in the same cycle -> ReadData1=-7 before the edge (bypass); after the edge, with RegWrite=0, reads -7.
- RegWrite=1, WAddr=26, WData=55 -> reg 26 still reads 0, no bypass; WriteViolation=1, ViolationCount=1. Repeat with WAddr=0 -> reads 0, ViolationCount=2.
- CNT_W=2, five blocked writes -> ViolationCount saturates at 3. Then ClearViolation together with a blocked write -> count=1, flag=1. Then ClearViolation alone -> 0, 0.
- Write reg 10 = 0xDEADBEEF, then assert Reset_n=0 mid-cycle (not at an edge) -> reg 10 immediately reads 110 and the counter clears. A write held during reset has no effect.
- ADDR_W=3, SP_IDX=7, SP_INIT=64, INIT_LO=2, INIT_HI=5 -> after reset, reg 7 reads 64, reg 5 reads 105, reg 6 reads 0. Writing reg 6 = 9 reads back 9.

Source files
------------

// File: rtl/regfile_bypass_param_if.sv
// rtl/regfile_bypass_param_if.sv - read/write/violation bundle for the parametrised register file
interface regfile_bypass_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
);
    logic        [ADDR_W-1:0] ReadReg1;
    logic        [ADDR_W-1:0] ReadReg2;
    logic        [ADDR_W-1:0] WAddr;
    logic signed [DATA_W-1:0] WData;
    logic                     RegWrite;
    logic                     ClearViolation;
    logic signed [DATA_W-1:0] ReadData1;
    logic signed [DATA_W-1:0] ReadData2;
    logic                     WriteViolation;
    logic        [CNT_W-1:0]  ViolationCount;

    modport master (
        output ReadReg1, ReadReg2, WAddr, WData, RegWrite, ClearViolation,
        input  ReadData1, ReadData2, WriteViolation, ViolationCount
    );

    modport slave (
        input  ReadReg1, ReadReg2, WAddr, WData, RegWrite, ClearViolation,
        output ReadData1, ReadData2, WriteViolation, ViolationCount
    );
endinterface

// File: rtl/regfile_bypass_param.sv
// rtl/regfile_bypass_param.sv - parametrised 2R1W register file with write bypass and write protection
module regfile_bypass_param #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 5,
    parameter logic [31:0] PROT_MASK   = 32'h0C000001,
    parameter int          INIT_LO     = 2,
    parameter int          INIT_HI     = 25,
    parameter int          INIT_OFFSET = 100,
    parameter int          SP_IDX      = 29,
    parameter int          SP_INIT     = 1020,
    parameter int          CNT_W       = 8
) (
    input logic                  Clk,
    input logic                  Reset_n,
    regfile_bypass_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Mask bits beyond the implemented depth are dropped; registers past bit 31 are never protected.
    function automatic logic [DEPTH-1:0] prot_eff();
        logic [DEPTH-1:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 32) m[i] = PROT_MASK[i];
        end
        return m;
    endfunction

    function automatic logic signed [DATA_W-1:0] init_val(input int idx);
        if (idx == SP_IDX)                        return DATA_W'(SP_INIT);
        else if (idx >= INIT_LO && idx <= INIT_HI) return DATA_W'(idx + INIT_OFFSET);
        else                                      return '0;
    endfunction

    localparam logic [DEPTH-1:0] PROT = prot_eff();

    logic signed [DATA_W-1:0] r_regs [DEPTH];
    logic                     r_violation;
    logic [CNT_W-1:0]         r_count;
    logic                     w_prot;
    logic                     w_legal;
    logic                     w_blocked;

    assign w_prot    = PROT[bus.WAddr];
    assign w_legal   = bus.RegWrite && !w_prot;
    assign w_blocked = bus.RegWrite && w_prot;

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_regs[g] <= init_val(g);
            end else if (w_legal && bus.WAddr == ADDR_W'(g)) begin
                r_regs[g] <= bus.WData;
            end
        end
    end

    // A clear coinciding with a blocked write restarts the count at one.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_violation <= 1'b0;
            r_count     <= '0;
        end else if (bus.ClearViolation) begin
            r_violation <= w_blocked;
            r_count     <= w_blocked ? CNT_W'(1) : '0;
        end else if (w_blocked) begin
            r_violation <= 1'b1;
            if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.ReadData1 = (bus.ReadReg1 == '0)                    ? '0 :
                           (w_legal && bus.WAddr == bus.ReadReg1) ? bus.WData :
                                                                    r_regs[bus.ReadReg1];
    assign bus.ReadData2 = (bus.ReadReg2 == '0)                    ? '0 :
                           (w_legal && bus.WAddr == bus.ReadReg2) ? bus.WData :
                                                                    r_regs[bus.ReadReg2];

    assign bus.WriteViolation = r_violation;
    assign bus.ViolationCount = r_count;
endmodule

// File: tb/tb_regfile_bypass_param.sv
// tb/tb_regfile_bypass_param.sv - directed vector bench for regfile_bypass_param
module tb_regfile_bypass_param;
    localparam int S_ADDR_W  = 3;
    localparam int S_INIT_LO = 2;
    localparam int S_INIT_HI = 5;
    localparam int S_SP_IDX  = 7;
    localparam int S_SP_INIT = 64;

    if (S_INIT_HI >= 2 ** S_ADDR_W || S_SP_IDX >= 2 ** S_ADDR_W) begin : g_param_check
        $error("small instance: INIT_HI or SP_IDX outside depth");
    end

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    regfile_bypass_param_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) bif0 ();
    regfile_bypass_param_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) bif1 ();
    regfile_bypass_param_if #(.DATA_W(32), .ADDR_W(S_ADDR_W), .CNT_W(8)) bif2 ();

    regfile_bypass_param u0 (.Clk(clk), .Reset_n(rst_n), .bus(bif0));
    regfile_bypass_param #(.CNT_W(2)) u1 (.Clk(clk), .Reset_n(rst_n), .bus(bif1));
    regfile_bypass_param #(
        .ADDR_W(S_ADDR_W), .INIT_LO(S_INIT_LO), .INIT_HI(S_INIT_HI),
        .SP_IDX(S_SP_IDX), .SP_INIT(S_SP_INIT)
    ) u2 (.Clk(clk), .Reset_n(rst_n), .bus(bif2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        clr;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        expv;
        logic [7:0]  expc;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{5'd5,  5'd29, 1'b0, 5'd0,  32'd0,        1'b0, 32'd105,      32'd1020, 1'b0, 8'd0};
        vecs[1]  = '{5'd1,  5'd31, 1'b0, 5'd0,  32'd0,        1'b0, 32'd0,        32'd0,    1'b0, 8'd0};
        vecs[2]  = '{5'd8,  5'd8,  1'b1, 5'd8,  -32'sd7,      1'b0, -32'sd7,      -32'sd7,  1'b0, 8'd0};
        vecs[3]  = '{5'd8,  5'd9,  1'b0, 5'd0,  32'd0,        1'b0, -32'sd7,      32'd109,  1'b0, 8'd0};
        vecs[4]  = '{5'd26, 5'd27, 1'b1, 5'd26, 32'd55,       1'b0, 32'd0,        32'd0,    1'b0, 8'd0};
        vecs[5]  = '{5'd0,  5'd26, 1'b1, 5'd0,  32'd5,        1'b0, 32'd0,        32'd0,    1'b1, 8'd1};
        vecs[6]  = '{5'd29, 5'd25, 1'b0, 5'd0,  32'd0,        1'b0, 32'd1020,     32'd125,  1'b1, 8'd2};
        vecs[7]  = '{5'd29, 5'd2,  1'b1, 5'd29, 32'd500,      1'b0, 32'd500,      32'd102,  1'b1, 8'd2};
        vecs[8]  = '{5'd29, 5'd3,  1'b0, 5'd0,  32'd0,        1'b0, 32'd500,      32'd103,  1'b1, 8'd2};
        vecs[9]  = '{5'd31, 5'd30, 1'b1, 5'd31, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 32'd0,    1'b1, 8'd2};
        vecs[10] = '{5'd31, 5'd1,  1'b0, 5'd0,  32'd0,        1'b1, 32'h7FFFFFFF, 32'd0,    1'b1, 8'd2};
        vecs[11] = '{5'd31, 5'd8,  1'b0, 5'd0,  32'd0,        1'b0, 32'h7FFFFFFF, -32'sd7,  1'b0, 8'd0};

        bif0.ReadReg1 = '0; bif0.ReadReg2 = '0; bif0.WAddr = '0; bif0.WData = '0;
        bif0.RegWrite = 1'b0; bif0.ClearViolation = 1'b0;
        bif1.ReadReg1 = '0; bif1.ReadReg2 = '0; bif1.WAddr = '0; bif1.WData = '0;
        bif1.RegWrite = 1'b0; bif1.ClearViolation = 1'b0;
        bif2.ReadReg1 = '0; bif2.ReadReg2 = '0; bif2.WAddr = '0; bif2.WData = '0;
        bif2.RegWrite = 1'b0; bif2.ClearViolation = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Inputs change after the falling edge; outputs are sampled before the next rising edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bif0.ReadReg1 = vecs[i].rr1;
            bif0.ReadReg2 = vecs[i].rr2;
            bif0.RegWrite = vecs[i].we;
            bif0.WAddr    = vecs[i].wa;
            bif0.WData    = vecs[i].wd;
            bif0.ClearViolation = vecs[i].clr;
            #1;
            chk($sformatf("vec%0d rd1", i), bif0.ReadData1, vecs[i].exp1);
            chk($sformatf("vec%0d rd2", i), bif0.ReadData2, vecs[i].exp2);
            chk($sformatf("vec%0d viol", i), {31'd0, bif0.WriteViolation}, {31'd0, vecs[i].expv});
            chk($sformatf("vec%0d cnt", i), {24'd0, bif0.ViolationCount}, {24'd0, vecs[i].expc});
        end

        // Mid-cycle asynchronous reset restores contents; a write held in reset is dropped.
        @(negedge clk);
        bif0.ClearViolation = 1'b0;
        bif0.RegWrite = 1'b1; bif0.WAddr = 5'd10; bif0.WData = 32'hDEADBEEF; bif0.ReadReg1 = 5'd10;
        #1 chk("rst bypass r10", bif0.ReadData1, 32'hDEADBEEF);
        @(negedge clk);
        bif0.WAddr = 5'd26; bif0.WData = 32'd1;
        @(negedge clk);
        bif0.RegWrite = 1'b0;
        #1;
        chk("rst pre r10", bif0.ReadData1, 32'hDEADBEEF);
        chk("rst pre cnt", {24'd0, bif0.ViolationCount}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst r10", bif0.ReadData1, 32'd110);
        chk("rst cnt", {24'd0, bif0.ViolationCount}, 32'd0);
        chk("rst viol", {31'd0, bif0.WriteViolation}, 32'd0);
        bif0.RegWrite = 1'b1; bif0.WAddr = 5'd11; bif0.WData = 32'd77; bif0.ReadReg1 = 5'd12;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bif0.RegWrite = 1'b0; bif0.ReadReg1 = 5'd11;
        rst_n = 1'b1;
        #1 chk("rst held write r11", bif0.ReadData1, 32'd111);

        // Two-bit counter saturation and clear precedence.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bif1.RegWrite = 1'b1; bif1.WAddr = 5'd27; bif1.WData = 32'd9; bif1.ReadReg1 = 5'd27;
            #1 chk($sformatf("sat blk%0d r27", k), bif1.ReadData1, 32'd0);
        end
        @(negedge clk);
        bif1.RegWrite = 1'b0;
        #1;
        chk("sat cnt", {30'd0, bif1.ViolationCount}, 32'd3);
        chk("sat viol", {31'd0, bif1.WriteViolation}, 32'd1);
        bif1.ClearViolation = 1'b1; bif1.RegWrite = 1'b1; bif1.WAddr = 5'd0;
        @(negedge clk);
        bif1.RegWrite = 1'b0;
        #1;
        chk("clr+blk cnt", {30'd0, bif1.ViolationCount}, 32'd1);
        chk("clr+blk viol", {31'd0, bif1.WriteViolation}, 32'd1);
        @(negedge clk);
        bif1.ClearViolation = 1'b0;
        #1;
        chk("clr cnt", {30'd0, bif1.ViolationCount}, 32'd0);
        chk("clr viol", {31'd0, bif1.WriteViolation}, 32'd0);

        // Eight-entry instance.
        @(negedge clk);
        bif2.ReadReg1 = 3'd7; bif2.ReadReg2 = 3'd5;
        #1;
        chk("small r7", bif2.ReadData1, 32'd64);
        chk("small r5", bif2.ReadData2, 32'd105);
        bif2.ReadReg1 = 3'd6; bif2.ReadReg2 = 3'd1;
        #1;
        chk("small r6", bif2.ReadData1, 32'd0);
        chk("small r1", bif2.ReadData2, 32'd0);
        bif2.RegWrite = 1'b1; bif2.WAddr = 3'd6; bif2.WData = 32'd9;
        @(negedge clk);
        bif2.RegWrite = 1'b0; bif2.ReadReg2 = 3'd6;
        #1;
        chk("small r6 wr p1", bif2.ReadData1, 32'd9);
        chk("small r6 wr p2", bif2.ReadData2, 32'd9);
        chk("small viol", {31'd0, bif2.WriteViolation}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
